// File: rtl/game_pkg.sv
// Shared definitions for the frogger game sequencer: state encoding, field widths,
// default timing and the BCD score helper.
package game_pkg;

   localparam int LEVEL_W = 4;
   localparam int LIVES_W = 3;
   localparam int TIMER_W = 8;

   typedef enum logic [2:0] {
      ST_ATTRACT   = 3'd0,
      ST_PLAY      = 3'd1,
      ST_DYING     = 3'd2,
      ST_LEVEL_UP  = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_t;

   localparam int DEF_MAX_LEVEL   = 8;
   localparam int DEF_START_LIVES = 3;
   localparam int DEF_DEATH_TICKS = 50;
   localparam int DEF_WIN_TICKS   = 50;
   localparam int DEF_OVER_TICKS  = 200;

   // Car speed formula used by frogger: period = CAR_BASE_PERIOD - level*CAR_LEVEL_STEP
   localparam int CAR_BASE_PERIOD = 20;
   localparam int CAR_LEVEL_STEP  = 2;

   function automatic logic [7:0] bcd_add_sat(input logic [7:0] bcd,
                                              input logic [LEVEL_W-1:0] inc);
      logic [7:0] sum;
      sum = 8'(bcd[7:4]) * 8'd10 + 8'(bcd[3:0]) + 8'(inc);
      if (sum > 8'd99)
         sum = 8'd99;
      return {4'(sum / 8'd10), 4'(sum % 8'd10)};
   endfunction

endpackage

// File: rtl/game_controller_tick_timer.sv
// Tick-gated saturating counter shared by all freeze states of the game sequencer.
// done fires on the tick that completes LIMIT ticks since the last clear.
module tick_timer #(
   parameter int W = 8
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         tick,
   input  logic [W-1:0] limit,
   output logic         done
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         count_reg <= '0;
      else if (clear)
         count_reg <= '0;
      else if (tick && (count_reg != '1))
         count_reg <= count_reg + 1'b1;
   end

   assign done = tick && (count_reg == limit - 1'b1);

endmodule

// File: rtl/game_controller.sv
// Frogger game sequencer: level, lives and round-restart control.
// Optional BCD score output enabled by defining GAME_CTRL_SCORE_EN.
module game_controller
   import game_pkg::*;
#(
   parameter int MAX_LEVEL   = DEF_MAX_LEVEL,
   parameter int START_LIVES = DEF_START_LIVES,
   parameter int DEATH_TICKS = DEF_DEATH_TICKS,
   parameter int WIN_TICKS   = DEF_WIN_TICKS,
   parameter int OVER_TICKS  = DEF_OVER_TICKS
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               tick,
   input  logic               start,
   input  logic               death_collision,
   input  logic               win_collision,
   output logic [LEVEL_W-1:0] current_level,
   output logic [LIVES_W-1:0] lives,
   output logic               round_reset,
   output logic               freeze,
   output logic               game_over,
   output logic [2:0]         state_dbg
`ifdef GAME_CTRL_SCORE_EN
   ,output logic [7:0]        score
`endif
);

   state_t               state_reg, state_next;
   logic [LEVEL_W-1:0]   level_reg, level_next;
   logic [LIVES_W-1:0]   lives_reg, lives_next;
   logic                 round_reset_reg, round_reset_next;
   logic                 start_meta_reg, start_sync_reg, start_prev_reg;
   logic                 start_edge;
   logic                 start_game, level_done;
   logic                 timer_clear, timer_done;
   logic [TIMER_W-1:0]   timer_limit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_meta_reg <= 1'b0;
         start_sync_reg <= 1'b0;
         start_prev_reg <= 1'b0;
      end else begin
         start_meta_reg <= start;
         start_sync_reg <= start_meta_reg;
         start_prev_reg <= start_sync_reg;
      end
   end

   assign start_edge = start_sync_reg && !start_prev_reg;

   always_comb begin
      timer_limit = '0;
      case (state_reg)
         ST_DYING:     timer_limit = TIMER_W'(DEATH_TICKS);
         ST_LEVEL_UP:  timer_limit = TIMER_W'(WIN_TICKS);
         ST_GAME_OVER: timer_limit = TIMER_W'(OVER_TICKS);
         default:      timer_limit = '0;
      endcase
   end

   tick_timer #(.W(TIMER_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .tick    (tick),
      .limit   (timer_limit),
      .done    (timer_done)
   );

   always_comb begin
      state_next       = state_reg;
      level_next       = level_reg;
      lives_next       = lives_reg;
      round_reset_next = 1'b0;
      timer_clear      = 1'b0;
      start_game       = 1'b0;
      level_done       = 1'b0;
      case (state_reg)
         ST_ATTRACT: begin
            timer_clear = 1'b1;
            // a start edge right after the GAME_OVER exit pulse would make round_reset two clks wide
            if (start_edge && !round_reset_reg)
               start_game = 1'b1;
         end
         ST_PLAY: begin
            timer_clear = 1'b1;
            // round_reset_reg marks the first PLAY clk, where stale flags are still high
            if (!round_reset_reg) begin
               if (death_collision) begin
                  lives_next = (lives_reg != '0) ? lives_reg - 1'b1 : '0;
                  state_next = (lives_reg <= LIVES_W'(1)) ? ST_GAME_OVER : ST_DYING;
               end else if (win_collision) begin
                  state_next = ST_LEVEL_UP;
               end
            end
         end
         ST_DYING: begin
            if (timer_done) begin
               round_reset_next = 1'b1;
               state_next       = ST_PLAY;
            end
         end
         ST_LEVEL_UP: begin
            if (timer_done) begin
               level_done       = 1'b1;
               level_next       = (level_reg == LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(1)
                                                                     : level_reg + 1'b1;
               round_reset_next = 1'b1;
               state_next       = ST_PLAY;
            end
         end
         ST_GAME_OVER: begin
            if (start_edge) begin
               start_game = 1'b1;
            end else if (timer_done) begin
               level_next       = LEVEL_W'(1);
               round_reset_next = 1'b1;
               state_next       = ST_ATTRACT;
            end
         end
         default: state_next = ST_ATTRACT;
      endcase
      if (start_game) begin
         lives_next       = LIVES_W'(START_LIVES);
         level_next       = LEVEL_W'(1);
         round_reset_next = 1'b1;
         state_next       = ST_PLAY;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= ST_ATTRACT;
         level_reg       <= LEVEL_W'(1);
         lives_reg       <= LIVES_W'(START_LIVES);
         round_reset_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         level_reg       <= level_next;
         lives_reg       <= lives_next;
         round_reset_reg <= round_reset_next;
      end
   end

   assign current_level = level_reg;
   assign lives         = lives_reg;
   assign round_reset   = round_reset_reg;
   assign freeze        = (state_reg != ST_PLAY);
   assign game_over     = (state_reg == ST_GAME_OVER);
   assign state_dbg     = 3'(state_reg);

`ifdef GAME_CTRL_SCORE_EN
   logic [7:0] score_reg;

   // score accumulates the level being left, so it uses the pre-increment value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         score_reg <= '0;
      else if (start_game)
         score_reg <= '0;
      else if (level_done)
         score_reg <= bcd_add_sat(score_reg, level_reg);
   end

   assign score = score_reg;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Randomised scoreboard bench for game_controller: round_reset pulses are the
// transactions, checked against a game-rule model kept at event level.
module tb_game_controller;

   localparam int MAXL = 8;
   localparam int SL   = 3;
   localparam int DT   = 50;
   localparam int WT   = 50;
   localparam int OT   = 200;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       death_collision = 1'b0;
   logic       win_collision = 1'b0;
   logic [3:0] current_level;
   logic [2:0] lives;
   logic       round_reset;
   logic       freeze;
   logic       game_over;
   logic [2:0] state_dbg;
`ifdef GAME_CTRL_SCORE_EN
   logic [7:0] score;
`endif

   always #5 clk = ~clk;

   game_controller #(
      .MAX_LEVEL   (MAXL),
      .START_LIVES (SL),
      .DEATH_TICKS (DT),
      .WIN_TICKS   (WT),
      .OVER_TICKS  (OT)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .tick            (tick),
      .start           (start),
      .death_collision (death_collision),
      .win_collision   (win_collision),
      .current_level   (current_level),
      .lives           (lives),
      .round_reset     (round_reset),
      .freeze          (freeze),
      .game_over       (game_over),
      .state_dbg       (state_dbg)
`ifdef GAME_CTRL_SCORE_EN
      ,.score          (score)
`endif
   );

   // st: 1 = round continues in PLAY, 0 = back to ATTRACT; -1 tick counts mean "don't care"
   typedef struct {
      int level;
      int lives;
      int st;
      int frz_ticks;
      int go_ticks;
      int score;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_e;
   int  n_checks = 0;
   int  n_fail = 0;
   int  m_level = 1;
   int  m_lives = SL;
   int  m_score = 0;
   int  frz_cnt = 0;
   int  go_cnt = 0;
   bit  prev_rr = 1'b0;
   int  n_ev = 0;

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic int dut_score();
`ifdef GAME_CTRL_SCORE_EN
      return int'(score[7:4]) * 10 + int'(score[3:0]);
`else
      return 0;
`endif
   endfunction

   task automatic summary();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
   endtask

   initial forever begin
      @(posedge clk);
      #1 tick = ($urandom_range(0, 2) == 0);
   end

   // Monitor: every round_reset pulse is a transaction popped from the scoreboard.
   always @(negedge clk) begin
      if (!reset_n) begin
         frz_cnt = 0;
         go_cnt  = 0;
         prev_rr = 1'b0;
      end else begin
         if (round_reset) begin
            check("rr_back_to_back", int'(prev_rr), 0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_round_reset: got pulse, expected none (t=%0t)", $time);
            end else begin
               mon_e = exp_q.pop_front();
               n_ev++;
               $display("ev %0d: level=%0d lives=%0d state=%0d frz_ticks=%0d go_ticks=%0d",
                        n_ev, current_level, lives, state_dbg, frz_cnt, go_cnt);
               check("ev_level", int'(current_level), mon_e.level);
               check("ev_lives", int'(lives), mon_e.lives);
               check("ev_state", int'(state_dbg), mon_e.st);
               check("ev_freeze", int'(freeze), (mon_e.st == 1) ? 0 : 1);
               check("ev_game_over", int'(game_over), 0);
               if (mon_e.frz_ticks >= 0)
                  check("ev_freeze_ticks", frz_cnt, mon_e.frz_ticks);
               if (mon_e.go_ticks >= 0)
                  check("ev_game_over_ticks", go_cnt, mon_e.go_ticks);
`ifdef GAME_CTRL_SCORE_EN
               check("ev_score", dut_score(), mon_e.score);
`endif
            end
            frz_cnt = 0;
            go_cnt  = 0;
         end else begin
            if (!freeze)
               frz_cnt = 0;
            else if (tick)
               frz_cnt++;
            if (game_over && tick)
               go_cnt++;
         end
         prev_rr = round_reset;
      end
   end

   task automatic wait_rr(input int budget, input string what);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!round_reset && k < budget);
      if (!round_reset) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout_%s: no round_reset within %0d clks", what, budget);
         summary();
         $finish;
      end
   endtask

   task automatic wait_game_over(input int budget);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!game_over && k < budget);
      if (!game_over) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout_game_over: game_over not seen within %0d clks", budget);
         summary();
         $finish;
      end
   endtask

   task automatic press_start();
      m_level = 1;
      m_lives = SL;
      m_score = 0;
      exp_q.push_back('{1, SL, 1, -1, -1, 0});
      @(negedge clk);
      start = 1'b1;
      wait_rr(20, "start");
      start = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_death(input bit both, input bit restart);
      if (m_lives == 1) begin
         if (restart) begin
            exp_q.push_back('{1, SL, 1, -1, -1, 0});
            death_collision = 1'b1;
            win_collision   = both;
            wait_game_over(20);
            death_collision = 1'b0;
            win_collision   = 1'b0;
            start = 1'b1;
            wait_rr(20, "restart");
            start = 1'b0;
            m_level = 1;
            m_lives = SL;
            m_score = 0;
            repeat (3) @(negedge clk);
         end else begin
            m_lives = 0;
            exp_q.push_back('{1, 0, 0, OT, OT, m_score});
            death_collision = 1'b1;
            win_collision   = both;
            wait_rr(4000, "game_over");
            death_collision = 1'b0;
            win_collision   = 1'b0;
            m_level = 1;
         end
      end else begin
         m_lives--;
         exp_q.push_back('{m_level, m_lives, 1, DT, 0, m_score});
         death_collision = 1'b1;
         win_collision   = both;
         wait_rr(1500, "death");
         death_collision = 1'b0;
         win_collision   = 1'b0;
      end
   endtask

   task automatic do_win();
      int old;
      old = m_level;
      m_level = (old == MAXL) ? 1 : old + 1;
      m_score = (m_score + old > 99) ? 99 : m_score + old;
      exp_q.push_back('{m_level, m_lives, 1, WT, 0, m_score});
      win_collision = 1'b1;
      wait_rr(1500, "win");
      win_collision = 1'b0;
   endtask

   initial begin
      int k;
      int act;
      repeat (3) @(negedge clk);
      check("rst_level", int'(current_level), 1);
      check("rst_lives", int'(lives), SL);
      check("rst_round_reset", int'(round_reset), 0);
      check("rst_freeze", int'(freeze), 1);
      check("rst_game_over", int'(game_over), 0);
      check("rst_state", int'(state_dbg), 0);
`ifdef GAME_CTRL_SCORE_EN
      check("rst_score", dut_score(), 0);
`endif
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      check("attract_freeze", int'(freeze), 1);

      press_start();
      for (int i = 0; i < MAXL; i++)
         do_win();
      check("wrap_level", int'(current_level), 1);
`ifdef GAME_CTRL_SCORE_EN
      check("score_8_wins", dut_score(), 36);
`endif
      do_death(1'b1, 1'b0);

      for (int i = 0; i < 30; i++) begin
         if (m_lives == 0) begin
            press_start();
         end else begin
            act = $urandom_range(0, 9);
            if (act < 6)
               do_win();
            else
               do_death(act == 9, ($urandom_range(0, 1) == 1));
         end
      end

      if (m_lives == 0)
         press_start();
      repeat (2) @(negedge clk);
      win_collision = 1'b1;
      k = 0;
      while (!freeze && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("levelup_freeze", int'(freeze), 1);
      k = 0;
      while (k < 30) begin
         @(negedge clk);
         if (tick)
            k++;
      end
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_level", int'(current_level), 1);
      check("async_rst_lives", int'(lives), SL);
      check("async_rst_round_reset", int'(round_reset), 0);
      check("async_rst_freeze", int'(freeze), 1);
      check("async_rst_state", int'(state_dbg), 0);
      win_collision = 1'b0;
      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_state", int'(state_dbg), 0);
      summary();
      $finish;
   end

endmodule
